// File: rtl/serial_deserializer.sv
// Multi-lane serial-to-parallel converter with start-strobe framing, one-word output buffer and valid/ready handshake.
// Define DESERIALIZER_PARITY_EN to require a trailing even-parity beat per word and report parity_err.
module serial_deserializer #(
  parameter int WORD_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  fast_clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      serial_in,
  input  logic                  serial_valid,
  input  logic                  frame_start,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  output logic                  sync_err,
  output logic                  parity_err
);

  localparam int BEATS = WORD_WIDTH / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PAR_BEAT  = CNT_W'(BEATS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

`ifdef DESERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic [0:0]            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [WORD_WIDTH-1:0] shift_reg, shift_next;
  logic [WORD_WIDTH-1:0] data_out_reg, data_out_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  overrun_reg, overrun_next;
  logic                  sync_err_reg, sync_err_next;
  logic                  parity_err_reg, parity_err_next;

  logic                  start;
  logic [WORD_WIDTH-1:0] shift_base;
  logic [WORD_WIDTH-1:0] shifted;
  logic                  complete;
  logic [WORD_WIDTH-1:0] word_done;
  logic                  perr_done;

  assign start      = serial_valid & frame_start;
  // A start beat always assembles onto an empty word so stale partial bits never leak.
  assign shift_base = start ? '0 : shift_reg;

  // After BEATS shifts every beat lands at the index the lane mapping requires.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      logic [LANES-1:0] lane_rev;
      for (genvar gi = 0; gi < LANES; gi++) begin : g_rev
        assign lane_rev[gi] = serial_in[LANES-1-gi];
      end
      if (LANES == WORD_WIDTH) begin : g_full
        assign shifted = lane_rev;
      end else begin : g_part
        assign shifted = {shift_base[WORD_WIDTH-LANES-1:0], lane_rev};
      end
    end else begin : g_lsb
      if (LANES == WORD_WIDTH) begin : g_full
        assign shifted = serial_in;
      end else begin : g_part
        assign shifted = {serial_in, shift_base[WORD_WIDTH-1:LANES]};
      end
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    data_out_next   = data_out_reg;
    data_valid_next = data_valid_reg;
    parity_err_next = parity_err_reg;
    overrun_next    = 1'b0;
    sync_err_next   = 1'b0;
    complete        = 1'b0;
    word_done       = shifted;
    perr_done       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          shift_next = shifted;
          cnt_next   = CNT_W'(1);
          if (!PARITY_EN && BEATS == 1) complete = 1'b1;
          else state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          sync_err_next = 1'b1;
          shift_next    = shifted;
          cnt_next      = CNT_W'(1);
        end else if (serial_valid) begin
          if (PARITY_EN && cnt_reg == PAR_BEAT) begin
            complete  = 1'b1;
            word_done = shift_reg;
            perr_done = (^shift_reg) ^ serial_in[0];
          end else begin
            shift_next = shifted;
            cnt_next   = cnt_reg + CNT_W'(1);
            if (!PARITY_EN && cnt_reg == LAST_DATA) complete = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (complete) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      if (!data_valid_reg || data_ready) begin
        data_out_next   = word_done;
        data_valid_next = 1'b1;
        parity_err_next = perr_done;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (data_valid_reg && data_ready) begin
      data_valid_next = 1'b0;
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      sync_err_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      overrun_reg    <= overrun_next;
      sync_err_reg   <= sync_err_next;
      parity_err_reg <= parity_err_next;
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign overrun    = overrun_reg;
  assign sync_err   = sync_err_reg;
  assign parity_err = parity_err_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: two instances (1-lane LSB-first, 4-lane MSB-first) checked every cycle
// against a word-level reference model, plus directed literal expectations.
module tb_serial_deserializer;

  localparam int W = 16;
`ifdef DESERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      sv, fs, rdy;
  logic [0:0]      sin_a;
  logic [3:0]      sin_b;
  logic [1:0][W-1:0] dout;
  logic [1:0]      dv, ov, se, pe;

  int checks = 0;
  int failures = 0;

  serial_deserializer #(.WORD_WIDTH(16), .LANES(1), .MSB_FIRST(0)) dut_a (
    .fast_clk(clk), .reset(rst), .serial_in(sin_a), .serial_valid(sv[0]),
    .frame_start(fs[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .overrun(ov[0]), .sync_err(se[0]), .parity_err(pe[0])
  );

  serial_deserializer #(.WORD_WIDTH(16), .LANES(4), .MSB_FIRST(1)) dut_b (
    .fast_clk(clk), .reset(rst), .serial_in(sin_b), .serial_valid(sv[1]),
    .frame_start(fs[1]), .data_out(dout[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .overrun(ov[1]), .sync_err(se[1]), .parity_err(pe[1])
  );

  // Reference model: word-level bookkeeping from the framing and bit-index rules.
  bit           model_live = 1'b0;
  bit           m_in_frame [2];
  int           m_cnt      [2];
  logic [W-1:0] m_word     [2];
  logic [W-1:0] m_out      [2];
  bit           m_dv [2];
  bit           m_pe [2];
  bit           m_ov [2];
  bit           m_se [2];

  function automatic int lanes_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit in_bit(int i, int j);
    return (i == 0) ? sin_a[0] : sin_b[j];
  endfunction

  function automatic int bit_index(int i, int k, int j);
    int idx;
    idx = k * lanes_of(i) + j;
    return (i == 0) ? idx : (W - 1 - idx);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_in_frame[i] = 1'b0; m_cnt[i] = 0; m_word[i] = '0; m_out[i] = '0;
        m_dv[i] = 1'b0; m_pe[i] = 1'b0; m_ov[i] = 1'b0; m_se[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit done;
        bit dperr;
        int nb;
        done = 1'b0;
        dperr = 1'b0;
        nb = W / lanes_of(i);
        m_ov[i] = 1'b0;
        m_se[i] = 1'b0;
        if (sv[i] && fs[i]) begin
          if (m_in_frame[i]) m_se[i] = 1'b1;
          m_word[i] = '0;
          for (int j = 0; j < lanes_of(i); j++) m_word[i][bit_index(i, 0, j)] = in_bit(i, j);
          m_cnt[i] = 1;
          m_in_frame[i] = 1'b1;
          if (!PAR && nb == 1) done = 1'b1;
        end else if (sv[i] && m_in_frame[i]) begin
          if (m_cnt[i] == nb) begin
            done = 1'b1;
            dperr = (^m_word[i]) ^ in_bit(i, 0);
          end else begin
            for (int j = 0; j < lanes_of(i); j++) m_word[i][bit_index(i, m_cnt[i], j)] = in_bit(i, j);
            m_cnt[i] = m_cnt[i] + 1;
            if (!PAR && m_cnt[i] == nb) done = 1'b1;
          end
        end
        if (done) begin
          m_in_frame[i] = 1'b0;
          if (!m_dv[i] || rdy[i]) begin
            m_out[i] = m_word[i];
            m_dv[i] = 1'b1;
            m_pe[i] = dperr;
          end else begin
            m_ov[i] = 1'b1;
          end
        end else if (m_dv[i] && rdy[i]) begin
          m_dv[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(string name, int inst, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h required=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < 2; i++) begin
        chk("data_valid", i, W'(dv[i]), W'(m_dv[i]));
        chk("data_out",   i, dout[i],    m_out[i]);
        chk("overrun",    i, W'(ov[i]), W'(m_ov[i]));
        chk("sync_err",   i, W'(se[i]), W'(m_se[i]));
        chk("parity_err", i, W'(pe[i]), W'(m_pe[i]));
      end
    end
  end

  // Stimulus helpers: inputs change on the falling edge only.
  task automatic drive(int i, logic [3:0] d, bit start);
    sv[i] = 1'b1;
    fs[i] = start;
    if (i == 0) sin_a = d[0:0];
    else        sin_b = d;
    @(negedge clk);
    sv[i] = 1'b0;
    fs[i] = 1'b0;
  endtask

  function automatic logic [3:0] beat_data(int i, logic [W-1:0] w, int k);
    logic [3:0] r;
    r = '0;
    if (i == 0) r[0] = w[k];
    else for (int j = 0; j < 4; j++) r[j] = w[W-1-(4*k+j)];
    return r;
  endfunction

  task automatic send_beats(int i, logic [W-1:0] w, int k0, int k1, bit fs_first, int gap);
    for (int k = k0; k <= k1; k++) begin
      if (k != k0) repeat (gap) @(negedge clk);
      drive(i, beat_data(i, w, k), fs_first && (k == k0));
    end
  endtask

  task automatic send_parity(int i, bit p);
    if (PAR) drive(i, {3'b000, p}, 1'b0);
  endtask

  task automatic send_word(int i, logic [W-1:0] w);
    send_beats(i, w, 0, W / lanes_of(i) - 1, 1'b1, 0);
    send_parity(i, ^w);
  endtask

  initial begin
    rst = 1'b1; sv = '0; fs = '0; rdy = 2'b11; sin_a = '0; sin_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_dv",   0, W'(dv[0]), '0);
    chk("reset_dout", 1, dout[1],   '0);
    rst = 1'b0;
    @(negedge clk);

    // 1-lane LSB-first word with an always-ready consumer.
    send_word(0, 16'hA5C3);
    chk("lit_a5c3", 0, dout[0], 16'hA5C3);
    chk("lit_a5c3_dv", 0, W'(dv[0]), 16'h1);
    @(negedge clk);
    chk("lit_a5c3_drop", 0, W'(dv[0]), 16'h0);

    // 4-lane MSB-first word with two idle cycles between beats.
    send_beats(1, 16'hDEAF, 0, 3, 1'b1, 2);
    send_parity(1, ^16'hDEAF);
    chk("lit_deaf", 1, dout[1], 16'hDEAF);
    chk("lit_deaf_dv", 1, W'(dv[1]), 16'h1);
    @(negedge clk);

    // Stalled consumer: second word overruns, first word is kept.
    rdy[0] = 1'b0;
    send_word(0, 16'h1111);
    chk("lit_ovr_first", 0, dout[0], 16'h1111);
    chk("lit_ovr_none", 0, W'(ov[0]), 16'h0);
    send_word(0, 16'h2222);
    chk("lit_ovr_pulse", 0, W'(ov[0]), 16'h1);
    chk("lit_ovr_keep", 0, dout[0], 16'h1111);
    @(negedge clk);
    chk("lit_ovr_once", 0, W'(ov[0]), 16'h0);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("lit_ovr_drain", 0, W'(dv[0]), 16'h0);

    // Restart on beat 7 of a word.
    send_beats(0, 16'h0000, 0, 6, 1'b1, 0);
    send_beats(0, 16'hBEEF, 0, 0, 1'b1, 0);
    chk("lit_sync_pulse", 0, W'(se[0]), 16'h1);
    send_beats(0, 16'hBEEF, 1, 15, 1'b0, 0);
    send_parity(0, ^16'hBEEF);
    chk("lit_beef", 0, dout[0], 16'hBEEF);
    chk("lit_sync_gone", 0, W'(se[0]), 16'h0);
    @(negedge clk);

`ifdef DESERIALIZER_PARITY_EN
    send_beats(0, 16'h0001, 0, 15, 1'b1, 0);
    send_parity(0, 1'b1);
    chk("lit_par_ok", 0, W'(pe[0]), 16'h0);
    chk("lit_par_ok_word", 0, dout[0], 16'h0001);
    @(negedge clk);
    send_beats(0, 16'h0001, 0, 15, 1'b1, 0);
    send_parity(0, 1'b0);
    chk("lit_par_bad", 0, W'(pe[0]), 16'h1);
    chk("lit_par_bad_dv", 0, W'(dv[0]), 16'h1);
    @(negedge clk);
`endif

    // Reset during beat 9 while a word is pending, then orphan beats.
    rdy[0] = 1'b0;
    send_word(0, 16'h3C3C);
    send_beats(0, 16'h5A5A, 0, 8, 1'b1, 0);
    rst = 1'b1;
    drive(0, beat_data(0, 16'h5A5A, 9), 1'b0);
    rst = 1'b0;
    chk("lit_rst_dv", 0, W'(dv[0]), 16'h0);
    chk("lit_rst_dout", 0, dout[0], 16'h0);
    send_beats(0, 16'h5A5A, 10, 15, 1'b0, 0);
    send_parity(0, 1'b0);
    @(negedge clk);
    chk("lit_rst_ignored", 0, W'(dv[0]), 16'h0);
    rdy[0] = 1'b1;

    // Randomised traffic on both instances.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        sv[i]  = ($urandom_range(0, 9) < 8);
        fs[i]  = ($urandom_range(0, (i == 0) ? 17 : 5) == 0);
        rdy[i] = ($urandom_range(0, 3) != 0);
      end
      sin_a = 1'($urandom_range(0, 1));
      sin_b = 4'($urandom_range(0, 15));
      rst   = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    rst = 1'b0; sv = '0; fs = '0; rdy = 2'b11;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Parametrised multi-lane serial-to-parallel converter with framing, a one-word output buffer and a valid/ready handshake. It sits at the chip's serial input pins on the fast clock domain and delivers complete words to downstream logic. Each word is delimited by an explicit start strobe, so a stalled consumer cannot corrupt alignment. Overruns and framing violations are flagged rather than silently merged.

## Interface
- `WORD_WIDTH`, default 16: bits per assembled word; must be an integer multiple of `LANES`.
- `LANES`, default 1: serial bits received per beat; legal range 1..`WORD_WIDTH`.
- `MSB_FIRST`, default 0: 0 sends the least significant bits first; 1 sends the most significant bits first.
- `fast_clk`, input, 1: the only clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `serial_in`, input, `LANES`: serial data for the current beat.
- `serial_valid`, input, 1: `serial_in` holds a beat this cycle.
- `frame_start`, input, 1: qualified by `serial_valid`; marks beat 0 of a word.
- `data_out`, output, `WORD_WIDTH`: assembled word.
- `data_valid`, output, 1: `data_out` holds an undelivered word.
- `data_ready`, input, 1: the consumer accepts the word this cycle.
- `overrun`, output, 1: one-cycle pulse; a completed word was dropped.
- `sync_err`, output, 1: one-cycle pulse; `frame_start` arrived mid-word.
- `parity_err`, output, 1: parity flag for the word in `data_out`; valid while `data_valid` is high.

## Operation
- `BEATS` = `WORD_WIDTH`/`LANES`. The beat counter width is clog2(`BEATS`+1).
- States:
  - IDLE: beats without `frame_start` are ignored. A beat with `frame_start` is captured as beat 0, then the block moves to SHIFT (or to COMPLETE directly when `BEATS`==1).
  - SHIFT: each beat with `serial_valid` high is captured and the counter increments. Cycles with `serial_valid` low are gaps and change nothing.
- Bit mapping, beat k, lane j:
  - `MSB_FIRST`=0: the bit goes to index k·`LANES`+j.
  - `MSB_FIRST`=1: the bit goes to index `WORD_WIDTH`-1-(k·`LANES`+j).
- Word completion (final data beat, or the parity beat when parity is enabled):
  - The word is loaded into the output register if `data_valid` is low, or if `data_valid` and `data_ready` are both high in that cycle.
  - Otherwise the word is discarded, `overrun` pulses, and the output register is unchanged.
  - In both cases the block returns to IDLE.
- `frame_start` with `serial_valid` while in SHIFT:
  - The partial word is discarded and `sync_err` pulses.
  - The current beat is captured as beat 0 of a new word, and the state stays SHIFT.
- Handshake:
  - A transfer occurs on any cycle with `data_valid` and `data_ready` both high.
  - `data_valid` stays high, and `data_out`/`parity_err` stay stable, until a transfer occurs.
  - `data_ready` has no effect while `data_valid` is low.
  - A transfer in the same cycle as a completion loads the new word; `data_valid` stays high.
- Reset: state IDLE, counter 0, shift register 0. `data_out`=0, `data_valid`=0, `overrun`=0, `sync_err`=0, `parity_err`=0. Reset takes priority over all other activity, including a completion in the same cycle.

## Timing
- `data_valid` rises on the clock edge that registers the completing beat. The word is first visible the cycle after that beat is presented.
- Minimum word period is `BEATS` cycles, or `BEATS`+1 with parity enabled. Back-to-back words need no idle cycle.
- `overrun` and `sync_err` are registered and high for exactly one cycle after the triggering beat.
- No combinational path exists from any input to any output.

## Configuration
- `DESERIALIZER_PARITY_EN` defined:
  - After the final data beat, one extra beat is required. Its `serial_in[0]` is the even-parity bit over the word; other lanes are ignored.
  - `parity_err` = XOR of the data bits and the parity bit, registered together with `data_out`.
  - `frame_start` on the parity beat is handled as a mid-word restart.
- `DESERIALIZER_PARITY_EN` undefined: there is no parity beat, completion happens on the final data beat, and `parity_err` is tied to 0.

## Test plan
- `WORD_WIDTH`=16, `LANES`=1, `MSB_FIRST`=0, `data_ready`=1: send 0xA5C3 LSB first, starting with `frame_start` -> `data_out`=0xA5C3 with `data_valid` high for one cycle, 16 cycles after beat 0.
- `LANES`=4, `MSB_FIRST`=1: send beats 0xD, 0xE, 0xA, 0xF with `serial_valid` gaps between them -> `data_out`=0xDEAF, and the gaps do not change the result.
- Hold `data_ready`=0 and send two words 0x1111 then 0x2222 -> `data_out` stays 0x1111, `overrun` pulses once at completion of the second word, and a later transfer leaves `data_valid`=0.
- Assert `frame_start` on beat 7 of a word, then send 16 beats of 0xBEEF -> `sync_err` pulses once and `data_out`=0xBEEF.
- With `DESERIALIZER_PARITY_EN`, send 0x0001 with parity bit 1 -> `parity_err`=0; send parity bit 0 -> `parity_err`=1, and the word is still delivered.
- Assert `reset` for one cycle during beat 9 -> all outputs are 0 the next cycle, and the remaining beats without `frame_start` are ignored.
